// File: rtl/down_count_monitor.sv
// down_count_monitor: watches a 4-bit down counter for 0->15 wraps, tallies them and raises an ack-cleared alarm.
// Optional macro STEP_CHECK_EN adds a sticky illegal-step flag; without it step_err is tied low.
module down_count_monitor #(
    parameter int WRAP_W     = 8,
    parameter int WRAP_LIMIT = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [3:0]        cnt_in,
    input  logic              ack,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              alarm,
    output logic              step_err
);
    typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

    localparam logic [WRAP_W-1:0] LIMIT = WRAP_W'(WRAP_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic [WRAP_W-1:0] count_q, count_d, count_base, count_inc;
    logic              pulse_q, pulse_d;
    logic              wrap, ack_ok;

    assign wrap   = (state_q != IDLE) && (prev_q == 4'd0) && (cnt_in == 4'd15);
    assign ack_ok = (state_q == ALARM) && ack;

    // An accepted ack restarts the tally before any same-cycle wrap is added.
    always_comb begin
        state_d    = state_q;
        prev_d     = cnt_in;
        count_d    = count_q;
        pulse_d    = 1'b0;
        count_base = ack_ok ? '0 : count_q;
        count_inc  = (count_base == '1) ? count_base : count_base + WRAP_W'(1);
        if (state_q == IDLE) begin
            state_d = TRACK;
        end else begin
            pulse_d = wrap;
            count_d = wrap ? count_inc : count_base;
            if (ack_ok) state_d = TRACK;
            if (wrap && count_inc == LIMIT) state_d = ALARM;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            prev_q  <= 4'd0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign wrap_pulse = pulse_q;
    assign wrap_count = count_q;
    assign alarm      = (state_q == ALARM);

`ifdef STEP_CHECK_EN
    logic err_q, err_d, bad_step;

    // Legal moves: hold, decrement by one, or synchronous clear to zero.
    always_comb begin
        bad_step = (state_q != IDLE) && (cnt_in != prev_q) && (cnt_in != prev_q - 4'd1) && (cnt_in != 4'd0);
        err_d    = (err_q && !ack_ok) || bad_step;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign step_err = err_q;
`else
    assign step_err = 1'b0;
`endif
endmodule

// File: tb/tb_down_count_monitor.sv
// tb_down_count_monitor: randomized and directed checks of two monitor configurations against a behavioural model.
module tb_down_count_monitor;
    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       wp_a, al_a, er_a, wp_b, al_b, er_b;
    logic [7:0] wc_a;
    logic [1:0] wc_b;
    logic [15:0] got;
    int checks = 0;
    int failures = 0;

    int lim[2] = '{4, 3};
    int mx[2]  = '{255, 3};
    bit trk[2], al[2], wp[2], er[2];
    int cnt[2], prv[2];

    always #5 clk = ~clk;

    down_count_monitor #(.WRAP_W(8), .WRAP_LIMIT(4)) dut_a (
        .clk(clk), .clear(clear), .cnt_in(cnt_in), .ack(ack),
        .wrap_pulse(wp_a), .wrap_count(wc_a), .alarm(al_a), .step_err(er_a)
    );
    down_count_monitor #(.WRAP_W(2), .WRAP_LIMIT(3)) dut_b (
        .clk(clk), .clear(clear), .cnt_in(cnt_in), .ack(ack),
        .wrap_pulse(wp_b), .wrap_count(wc_b), .alarm(al_b), .step_err(er_b)
    );

    assign got = {wp_a, wc_a, al_a, er_a, wp_b, wc_b, al_b, er_b};

    task automatic model(input logic [3:0] c, input logic a);
        for (int i = 0; i < 2; i++) begin
            if (!clear) begin
                trk[i] = 0; al[i] = 0; wp[i] = 0; er[i] = 0; cnt[i] = 0; prv[i] = 0;
            end else if (!trk[i]) begin
                trk[i] = 1; prv[i] = int'(c); wp[i] = 0;
            end else begin
                bit w;
                w = (prv[i] == 0) && (c == 4'd15);
                if (al[i] && a) begin
                    cnt[i] = 0; al[i] = 0; er[i] = 0;
                end
                wp[i] = w;
                if (w) begin
                    cnt[i] = (cnt[i] + 1 > mx[i]) ? mx[i] : cnt[i] + 1;
                    if (cnt[i] == lim[i]) al[i] = 1;
                end
`ifdef STEP_CHECK_EN
                if (!(int'(c) == prv[i] || int'(c) == (prv[i] + 15) % 16 || c == 4'd0)) er[i] = 1;
`endif
                prv[i] = int'(c);
            end
        end
    endtask

    function automatic logic [15:0] expv();
        return {wp[0], 8'(cnt[0]), al[0], er[0], wp[1], 2'(cnt[1]), al[1], er[1]};
    endfunction

    task automatic step(input logic [3:0] c, input logic a);
        cnt_in = c;
        ack = a;
        @(posedge clk);
        model(c, a);
        #2;
    endtask

    task automatic down_cycle();
        for (int v = 14; v >= 0; v--) step(4'(v), 1'b0);
        step(4'd15, 1'b0);
    endtask

    task automatic test_reset();
        clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(4'($urandom), 1'($urandom));
            if (got !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d got=%h exp=0000", i, got);
            end
            checks++;
        end
        clear = 1'b1;
        step(4'd5, 1'b0);
        step(4'd4, 1'b0);
        if (got !== expv()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", got, expv());
        end
        checks++;
    endtask

    task automatic test_wrap();
        logic [3:0] seq [6] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
        int pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b0);
            pulses += int'(wp_a);
            if (got !== expv()) begin
                failures++;
                $display("FAIL wrap step %0d got=%h exp=%h", i, got, expv());
            end
            checks++;
        end
        if (pulses != 1 || wc_a !== 8'd1) begin
            failures++;
            $display("FAIL wrap_once pulses=%0d count=%0d exp pulses=1 count=1", pulses, wc_a);
        end
        checks++;
    endtask

    task automatic test_alarm();
        for (int k = 0; k < 3; k++) begin
            down_cycle();
            if (got !== expv()) begin
                failures++;
                $display("FAIL alarm_cycle %0d got=%h exp=%h", k, got, expv());
            end
            checks++;
        end
        if (al_a !== 1'b1 || wc_a !== 8'd4) begin
            failures++;
            $display("FAIL alarm_raise alarm=%b count=%0d exp alarm=1 count=4", al_a, wc_a);
        end
        checks++;
        down_cycle();
        if (al_a !== 1'b1 || wc_a !== 8'd5) begin
            failures++;
            $display("FAIL alarm_keep alarm=%b count=%0d exp alarm=1 count=5", al_a, wc_a);
        end
        checks++;
        step(4'd14, 1'b1);
        if (al_a !== 1'b0 || wc_a !== 8'd0 || got !== expv()) begin
            failures++;
            $display("FAIL alarm_ack got=%h exp=%h", got, expv());
        end
        checks++;
        step(4'd14, 1'b0);
    endtask

    task automatic test_ack_wrap();
        for (int k = 0; k < 4; k++) down_cycle();
        if (al_a !== 1'b1) begin
            failures++;
            $display("FAIL ackwrap_setup alarm=%b exp=1", al_a);
        end
        checks++;
        for (int v = 14; v >= 0; v--) step(4'(v), 1'b0);
        step(4'd15, 1'b1);
        if (wp_a !== 1'b1 || wc_a !== 8'd1 || al_a !== 1'b0 || got !== expv()) begin
            failures++;
            $display("FAIL ack_with_wrap got=%h exp=%h", got, expv());
        end
        checks++;
        step(4'd14, 1'b0);
        if (wp_a !== 1'b0 || got !== expv()) begin
            failures++;
            $display("FAIL ack_with_wrap_after got=%h exp=%h", got, expv());
        end
        checks++;
    endtask

    task automatic test_hold_jump();
        logic [3:0] seq [10] = '{4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(seq[i], 1'b0);
            pulses += int'(wp_a);
            if (got !== expv()) begin
                failures++;
                $display("FAIL hold_jump step %0d got=%h exp=%h", i, got, expv());
            end
            checks++;
        end
        if (pulses != 0 || er_a !== 1'b0) begin
            failures++;
            $display("FAIL hold_jump_quiet pulses=%0d err=%b exp pulses=0 err=0", pulses, er_a);
        end
        checks++;
    endtask

    task automatic test_step_err();
        logic [3:0] seq [11] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd5, 4'd4, 4'd3, 4'd2};
        for (int i = 0; i < 11; i++) begin
            step(seq[i], i == 10);
            if (got !== expv()) begin
                failures++;
                $display("FAIL step_err step %0d got=%h exp=%h", i, got, expv());
            end
            checks++;
        end
`ifdef STEP_CHECK_EN
        if (er_a !== 1'b1) begin
            failures++;
            $display("FAIL step_err_sticky err=%b exp=1", er_a);
        end
        checks++;
`endif
        step(4'd1, 1'b0);
        step(4'd0, 1'b0);
        step(4'd15, 1'b0);
        step(4'd14, 1'b0);
        down_cycle();
        step(4'd14, 1'b1);
        if (al_a !== 1'b0 || er_a !== 1'b0 || got !== expv()) begin
            failures++;
            $display("FAIL step_err_ack_clear got=%h exp=%h", got, expv());
        end
        checks++;
    endtask

    task automatic test_random();
        logic [3:0] c = 4'd14;
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 70)      c = c - 4'd1;
            else if (r < 88 && r >= 82) c = 4'd0;
            else if (r < 92 && r >= 88) c = 4'd15;
            else if (r >= 92) c = 4'($urandom);
            step(c, $urandom_range(0, 9) == 0);
            if (got !== expv()) begin
                failures++;
                $display("FAIL random step %0d cnt=%0d got=%h exp=%h", i, c, got, expv());
            end
            checks++;
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 6; k++) begin
            step(4'd0, 1'b0);
            step(4'd15, 1'b0);
            if (got !== expv()) begin
                failures++;
                $display("FAIL saturate wrap %0d got=%h exp=%h", k, got, expv());
            end
            checks++;
        end
        if (wc_b !== 2'd3 || al_b !== 1'b1) begin
            failures++;
            $display("FAIL saturate_b count=%0d alarm=%b exp count=3 alarm=1", wc_b, al_b);
        end
        checks++;
        clear = 1'b0;
        #1;
        if (got !== 16'h0) begin
            failures++;
            $display("FAIL clear_async got=%h exp=0000", got);
        end
        checks++;
        step(4'd3, 1'b0);
        step(4'd3, 1'b0);
        clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'(3 - i), 1'b0);
            if (got !== expv()) begin
                failures++;
                $display("FAIL post_clear step %0d got=%h exp=%h", i, got, expv());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_alarm();
        test_ack_wrap();
        test_hold_jump();
        test_step_err();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
